program_fetch_arbiter: RTL

PROGRAM_FETCH_ARBITER -- requirements
Module: program_fetch_arbiter

---
 rtl/program_fetch_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/program_fetch_arbiter.sv
// program_fetch_arbiter: round-robin arbiter sharing one program memory port among per-core fetchers
module program_fetch_arbiter #(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_BITS  = 8,
  parameter int INSTR_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             core_read_valid,
  input  logic [NUM_CORES*ADDR_BITS-1:0]   core_read_address,
  output logic [NUM_CORES-1:0]             core_read_ready,
  output logic [NUM_CORES*INSTR_BITS-1:0]  core_read_data,
  output logic                             mem_read_valid,
  output logic [ADDR_BITS-1:0]             mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [INSTR_BITS-1:0]            mem_read_data
);
  localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WAIT_ACK} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, rr_n, grant, grant_n, hit_idx, idx;
  logic hit, mvalid_n;
  logic [ADDR_BITS-1:0] maddr_n;
  logic [NUM_CORES-1:0] ready_n;
  logic [NUM_CORES*INSTR_BITS-1:0] data_n;
  // first requesting core at or after rr_ptr, wrapping; descending scan so the nearest hit wins
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_CORES);
      if (core_read_valid[idx]) begin
        hit = 1'b1;
        hit_idx = idx;
      end
    end
  end
  // next state and next registered outputs; everything holds unless a transition fires
  always_comb begin
    state_n = state;
    rr_n = rr_ptr;
    grant_n = grant;
    mvalid_n = mem_read_valid;
    maddr_n = mem_read_address;
    ready_n = core_read_ready;
    data_n = core_read_data;
    if (state == IDLE) begin
      if (hit) begin
        state_n = WAIT_MEM;
        grant_n = hit_idx;
        mvalid_n = 1'b1;
        maddr_n = core_read_address[int'(hit_idx)*ADDR_BITS +: ADDR_BITS];
      end
    end else if (state == WAIT_MEM) begin
      if (mem_read_ready) begin
        state_n = WAIT_ACK;
        mvalid_n = 1'b0;
        ready_n = NUM_CORES'(1) << grant;
        data_n[int'(grant)*INSTR_BITS +: INSTR_BITS] = mem_read_data;
      end
    end else if (!core_read_valid[grant]) begin
      state_n = IDLE;
      ready_n = '0;
      rr_n = grant == PW'(NUM_CORES - 1) ? '0 : grant + 1'b1;
    end
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      mem_read_valid <= 1'b0;
      mem_read_address <= '0;
      core_read_ready <= '0;
      core_read_data <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      grant <= grant_n;
      mem_read_valid <= mvalid_n;
      mem_read_address <= maddr_n;
      core_read_ready <= ready_n;
      core_read_data <= data_n;
    end
  end
endmodule
